// File: rtl/bp_be_stride_detector.sv
// Reference-prediction table for committed loads: learns a per-PC constant stride and, once
// confident, hands one prefetch request to the BE prefetch generator over valid/ready.
module bp_be_stride_detector #(
    parameter int unsigned vaddr_width_p     = 39,
    parameter int unsigned dpath_width_gp    = 64,
    parameter int unsigned entries_p         = 16,
    parameter int unsigned tag_width_p       = 10,
    parameter int unsigned stride_width_p    = 8,
    parameter int unsigned loop_range_p      = 8,
    parameter int unsigned conf_width_p      = 2,
    parameter int unsigned conf_threshold_p  = 2,
    parameter int unsigned prefetch_degree_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      flush_i,
    input  logic                      ld_v_i,
    input  logic [vaddr_width_p-1:0]  ld_pc_i,
    input  logic [dpath_width_gp-1:0] ld_eff_addr_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [dpath_width_gp-1:0] eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic                      drop_o
);

    localparam int unsigned IdxW = $clog2(entries_p);
    localparam int unsigned DW   = dpath_width_gp;
    localparam int unsigned SW   = stride_width_p;
    localparam logic [conf_width_p-1:0] ConfThr = conf_width_p'(conf_threshold_p);
    localparam logic [loop_range_p-1:0] Degree  = loop_range_p'(prefetch_degree_p);

    // Reset asserts asynchronously but is released in step with the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [entries_p-1:0]    valid_q;
    logic [tag_width_p-1:0]  tag_q    [entries_p];
    logic [DW-1:0]           last_q   [entries_p];
    logic [SW-1:0]           stride_q [entries_p];
    logic [conf_width_p-1:0] conf_q   [entries_p];
    logic [loop_range_p-1:0] cool_q   [entries_p];

    logic [IdxW-1:0]         idx;
    logic [tag_width_p-1:0]  tag;
    logic                    hit, fits, match;
    logic [DW-1:0]           diff, diff_sext;
    logic [conf_width_p-1:0] conf_inc, new_conf;
    logic [SW-1:0]           new_stride;
    logic [loop_range_p-1:0] new_cool;
    logic                    want_trig, out_free, load_out, drop_d;
    logic                    unused_pc;

    assign idx = ld_pc_i[1 +: IdxW];
    assign tag = ld_pc_i[1+IdxW +: tag_width_p];
    assign unused_pc = ^{ld_pc_i[0], ld_pc_i[vaddr_width_p-1:1+IdxW+tag_width_p]};

    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign diff      = ld_eff_addr_i - last_q[idx];
    assign diff_sext = {{(DW-SW){diff[SW-1]}}, diff[SW-1:0]};
    assign fits      = (diff == diff_sext) && (diff != '0);
    assign match     = hit && fits && (diff[SW-1:0] == stride_q[idx]);
    assign conf_inc  = (conf_q[idx] == '1) ? conf_q[idx] : conf_q[idx] + 1'b1;

    assign want_trig = ld_v_i && !flush_i && match && (cool_q[idx] == '0) && (conf_inc >= ConfThr);
    assign out_free  = !v_o || ready_and_i;
    assign load_out  = want_trig && out_free;
    assign drop_d    = want_trig && !out_free;

    always_comb begin
        new_stride = stride_q[idx];
        new_conf   = conf_q[idx];
        new_cool   = cool_q[idx];
        if (!hit) begin
            new_stride = '0;
            new_conf   = '0;
            new_cool   = '0;
        end else if (match) begin
            new_conf = conf_inc;
            if (cool_q[idx] != '0) new_cool = cool_q[idx] - 1'b1;
            else if (load_out)     new_cool = Degree;
        end else begin
            new_stride = fits ? diff[SW-1:0] : '0;
            new_conf   = '0;
            new_cool   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < entries_p; k++) begin
                tag_q[k]    <= '0;
                last_q[k]   <= '0;
                stride_q[k] <= '0;
                conf_q[k]   <= '0;
                cool_q[k]   <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (ld_v_i) begin
            valid_q[idx]  <= 1'b1;
            tag_q[idx]    <= tag;
            last_q[idx]   <= ld_eff_addr_i;
            stride_q[idx] <= new_stride;
            conf_q[idx]   <= new_conf;
            cool_q[idx]   <= new_cool;
        end
    end

    // Output register: refills in the same cycle it is accepted, so back-to-back has no bubble.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            v_o        <= 1'b0;
            pc_o       <= '0;
            eff_addr_o <= '0;
            stride_o   <= '0;
            drop_o     <= 1'b0;
        end else if (flush_i) begin
            v_o    <= 1'b0;
            drop_o <= 1'b0;
        end else begin
            drop_o <= drop_d;
            if (load_out) begin
                v_o        <= 1'b1;
                pc_o       <= ld_pc_i;
                eff_addr_o <= ld_eff_addr_i;
                stride_o   <= diff[SW-1:0];
            end else if (ready_and_i) begin
                v_o <= 1'b0;
            end
        end
    end

    assign loop_counter_o = v_o ? Degree : '0;

endmodule

// File: doc/bp_be_stride_detector.md
Name: bp_be_stride_detector

Overview:
- Reference-prediction table that watches committed loads, learns a per-PC constant stride and tracks confidence.
- Once a stride is confident, issues one prefetch request (pc, eff_addr, stride, loop count) over a valid/ready handshake.
- Sits directly upstream of the BE prefetch generator and drives its pc/eff_addr/stride/loop_counter/v inputs.

Parameters:
- vaddr_width_p, from bp_params_p: virtual address width.
- dpath_width_gp, 64: effective address width.
- entries_p, 16: table entries, power of 2, direct-mapped.
- tag_width_p, 10: PC tag bits stored per entry.
- stride_width_p, 8: signed stride width sent downstream.
- loop_range_p, 8: width of loop_counter_o.
- conf_width_p, 2: saturating confidence counter width.
- conf_threshold_p, 2: minimum confidence needed to trigger.
- prefetch_degree_p, 4: prefetches per request and cooldown length; must be < 2^loop_range_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  invalidate all entries and drop any pending request.
- ld_v_i  in  1  committed load valid, one per cycle max.
- ld_pc_i  in  vaddr_width_p  load PC.
- ld_eff_addr_i  in  dpath_width_gp  load effective address.
- v_o  out  1  request valid.
- ready_and_i  in  1  generator ready; transfer occurs when v_o & ready_and_i.
- pc_o  out  vaddr_width_p  PC of the triggering load.
- eff_addr_o  out  dpath_width_gp  base address, the triggering load's address.
- stride_o  out  stride_width_p  signed stride.
- loop_counter_o  out  loop_range_p  number of prefetches, equal to prefetch_degree_p.
- drop_o  out  1  one-cycle pulse when a trigger is discarded because the output register is busy.

Behaviour:
- Reset (async assert, sync deassert internally):
  - All entries invalid.
  - v_o=0, drop_o=0.
  - pc_o/eff_addr_o/stride_o = 0; loop_counter_o = 0 while v_o=0.
- Index and tag:
  - idx = ld_pc_i[1 +: log2(entries_p)].
  - tag = the next tag_width_p PC bits above idx.
  - Lookup is combinational on flop storage; update is written at the clock edge.
- Entry contents: valid, tag, last_addr[dpath_width_gp], stride[stride_width_p] (signed), conf[conf_width_p], cool[loop_range_p].
- Stride computation on ld_v_i:
  - diff = ld_eff_addr_i - last_addr, 64-bit two's complement.
  - fits = (diff equals the sign-extension of diff[stride_width_p-1:0]) AND (diff != 0).
- Miss (invalid or tag mismatch): allocate or overwrite. Set valid=1, tag, last_addr=eff_addr, stride=0, conf=0, cool=0. No trigger.
- Hit with fits && diff[stride_width_p-1:0]==stride ("match"):
  - conf saturating-increments.
  - If cool!=0: cool decrements, no trigger.
  - Else if the post-increment conf >= conf_threshold_p: trigger.
- Hit, not match:
  - stride = fits ? diff[stride_width_p-1:0] : 0.
  - conf=0, cool=0, no trigger.
- Every hit writes last_addr=ld_eff_addr_i.
- Trigger handling:
  - If the output register is free (v_o=0) or is being freed this cycle (v_o & ready_and_i), load pc/eff_addr/stride/loop_counter and set v_o=1 next cycle. Set entry cool=prefetch_degree_p.
  - Otherwise pulse drop_o the next cycle and leave cool=0, so the next matching hit retries.
- Latency: v_o asserts the cycle after the triggering ld_v_i.
- Handshake:
  - v_o stays high and the payload stays stable until ready_and_i.
  - v_o does not depend combinationally on ready_and_i.
- Simultaneous accept and new trigger: the register refills and v_o stays high. This yields back-to-back requests with no bubble.
- flush_i:
  - Takes priority over ld_v_i in the same cycle.
  - Next cycle: all entries invalid, v_o=0, and a pending request is discarded even if ready_and_i is high.
- reset_n_i low mid-handshake: v_o drops immediately (async) and all state clears.
- Aliasing: a different PC mapping to the same idx is a miss and evicts the entry.

Test Plan:
- Learn and trigger: PC 0x8000_0100 loads 0x1000, 0x1008, 0x1010, 0x1018 with ready_and_i=1 -> v_o=1 for one cycle after the 4th load, with eff_addr_o=0x1018, stride_o=0x08, loop_counter_o=4, pc_o=0x8000_0100.
- Cooldown: continue the same PC with 0x1020…0x1040 -> no request for 0x1020–0x1038 (cool 4→0), next request at 0x1040.
- Negative and oversize strides:
  - Addresses 0x2000, 0x1FF8, 0x1FF0, 0x1FE8 -> stride_o=0xF8.
  - Addresses 0x1000, 0x2000, 0x3000, 0x4000 (diff 4096 does not fit) -> never v_o.
- Backpressure and drop:
  - Train PCs A and B; hold ready_and_i=0; trigger A, then B -> v_o holds A's payload and drop_o pulses once for B.
  - Raise ready_and_i with B triggering in the same cycle -> A accepted, B loaded, v_o stays 1.
- Stride break: after training stride 8, insert a load at +24 -> conf=0 and stride=24. Two further +24 loads (conf 0→1→2) -> trigger with stride_o=0x18 on the second of them.
- Flush/reset: with v_o=1 pending, assert flush_i -> v_o=0 next cycle and the 4-load sequence must retrain. Assert reset_n_i=0 mid-pending -> v_o=0 asynchronously.
